// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/sequencing controller:
// stage bit map, FSM encoding and the per-cycle control payload.
package pipe_ctrl_pkg;

   localparam int unsigned VEC_W = 5;
   localparam int unsigned XLEN  = 64;

   localparam int unsigned STG_PC  = 0;
   localparam int unsigned STG_ID  = 1;
   localparam int unsigned STG_EX  = 2;
   localparam int unsigned STG_MEM = 3;
   localparam int unsigned STG_WB  = 4;

   localparam logic [XLEN-1:0] ZeroWord = '0;

   typedef logic [VEC_W-1:0] stage_vec_t;

   typedef enum logic [1:0] {
      CTRL_RUN        = 2'd0,
      CTRL_DIV_WAIT   = 2'd1,
      CTRL_REDIR_PEND = 2'd2
   } ctrl_state_e;

   typedef struct packed {
      stage_vec_t stall;
      stage_vec_t flush;
      logic       redirect;
   } ctrl_out_t;

   // One-hot bit for the pipeline register feeding stage stg.
   function automatic stage_vec_t stage_bit(input int unsigned stg);
      return stage_vec_t'(1) << stg;
   endfunction

   // Hold every register from the PC up to and including stage stg.
   function automatic stage_vec_t stages_upto(input int unsigned stg);
      return (stage_vec_t'(1) << (stg + 1)) - stage_vec_t'(1);
   endfunction

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Free-running wrapping counter with increment enable.
module pipe_ctrl_cnt #(
   parameter int unsigned W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage hazard controller: prioritises hold requests into stall/flush
// vectors and a PC redirect, with divide watchdog and stall counters.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned DIV_TIMEOUT = 80,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hold_id_i,
   input  logic             div_start_i,
   input  logic             div_done_i,
   input  logic             jump_flag_i,
   input  logic [XLEN-1:0]  jump_addr_i,
   input  logic             if_wait_i,
   input  logic             mem_wait_i,
   output logic [VEC_W-1:0] stall_o,
   output logic [VEC_W-1:0] flush_o,
   output logic             redirect_o,
   output logic [XLEN-1:0]  redirect_addr_o,
   output logic             div_err_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   localparam int unsigned     WD_W    = $clog2(DIV_TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(DIV_TIMEOUT - 1);

   localparam stage_vec_t STALL_MEM = stages_upto(STG_MEM);
   localparam stage_vec_t FLUSH_MEM = stage_bit(STG_WB);
   localparam stage_vec_t STALL_DIV = stages_upto(STG_EX);
   localparam stage_vec_t FLUSH_DIV = stage_bit(STG_MEM);
   localparam stage_vec_t FLUSH_JMP = stage_bit(STG_ID) | stage_bit(STG_EX);
   localparam stage_vec_t STALL_LDU = stages_upto(STG_ID);
   localparam stage_vec_t FLUSH_LDU = stage_bit(STG_EX);
   localparam stage_vec_t STALL_IFW = stages_upto(STG_PC);
   localparam stage_vec_t FLUSH_IFW = stage_bit(STG_ID);

   ctrl_state_e     state_q, state_d;
   logic [XLEN-1:0] pend_q, pend_d;
   logic [WD_W-1:0] wd_q, wd_d;
   logic            err_q, err_d;
   ctrl_out_t       ctrl;
   logic            div_hold;
   logic            redir_req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CTRL_RUN;
         pend_q  <= ZeroWord;
         wd_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      wd_d    = wd_q;
      err_d   = err_q;
      ctrl    = '0;

      // The divider-done cycle is never stalled so its result can advance.
      div_hold  = ((state_q == CTRL_DIV_WAIT) || ((state_q == CTRL_RUN) && div_start_i))
                  && !div_done_i;
      redir_req = (state_q == CTRL_REDIR_PEND) || jump_flag_i;

      if (mem_wait_i) begin
         ctrl.stall = STALL_MEM;
         ctrl.flush = FLUSH_MEM;
      end else if (div_hold) begin
         ctrl.stall = STALL_DIV;
         ctrl.flush = FLUSH_DIV;
      end else if (redir_req) begin
         ctrl.redirect = 1'b1;
         ctrl.flush    = FLUSH_JMP;
      end else if (hold_id_i) begin
         ctrl.stall = STALL_LDU;
         ctrl.flush = FLUSH_LDU;
      end else if (if_wait_i) begin
         ctrl.stall = STALL_IFW;
         ctrl.flush = FLUSH_IFW;
      end

      case (state_q)
         CTRL_RUN: begin
            if (div_start_i && !div_done_i && !mem_wait_i) begin
               state_d = CTRL_DIV_WAIT;
               wd_d    = '0;
            end else if (jump_flag_i && mem_wait_i) begin
               state_d = CTRL_REDIR_PEND;
               pend_d  = jump_addr_i;
            end
         end
         CTRL_DIV_WAIT: begin
            if (div_done_i) begin
               state_d = CTRL_RUN;
            end else if (wd_q == WD_LAST) begin
               state_d = CTRL_RUN;
               err_d   = 1'b1;
            end else begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         CTRL_REDIR_PEND: begin
            if (!mem_wait_i) begin
               state_d = CTRL_RUN;
               pend_d  = ZeroWord;
            end
         end
         default: state_d = CTRL_RUN;
      endcase
   end

   assign stall_o         = ctrl.stall;
   assign flush_o         = ctrl.flush;
   assign redirect_o      = ctrl.redirect;
   assign redirect_addr_o = (state_q == CTRL_REDIR_PEND) ? pend_q : jump_addr_i;
   assign div_err_o       = err_q;

   pipe_ctrl_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (stall_o[STG_PC]),
      .cnt   (stall_cnt_o)
   );

   pipe_ctrl_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (redirect_o),
      .cnt   (flush_cnt_o)
   );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the priority rules.
module tb_pipe_ctrl;

   localparam int unsigned TO = 80;
   localparam logic [63:0] JA = 64'h0000_0000_8000_0100;

   logic        clk, rst_n;
   logic        hold_id_i, div_start_i, div_done_i, jump_flag_i, if_wait_i, mem_wait_i;
   logic [63:0] jump_addr_i, redirect_addr_o;
   logic [4:0]  stall_o, flush_o;
   logic        redirect_o, div_err_o;
   logic [31:0] stall_cnt_o, flush_cnt_o;
   int          n_vec, n_bad;

   pipe_ctrl #(.DIV_TIMEOUT(TO), .CNT_W(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .hold_id_i       (hold_id_i),
      .div_start_i     (div_start_i),
      .div_done_i      (div_done_i),
      .jump_flag_i     (jump_flag_i),
      .jump_addr_i     (jump_addr_i),
      .if_wait_i       (if_wait_i),
      .mem_wait_i      (mem_wait_i),
      .stall_o         (stall_o),
      .flush_o         (flush_o),
      .redirect_o      (redirect_o),
      .redirect_addr_o (redirect_addr_o),
      .div_err_o       (div_err_o),
      .stall_cnt_o     (stall_cnt_o),
      .flush_cnt_o     (flush_cnt_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one cycle of inputs at the falling edge, settle, then return.
   task automatic drive(input logic h, input logic ds, input logic dd, input logic jf,
                        input logic [63:0] ja, input logic iw, input logic mw);
      @(negedge clk);
      hold_id_i = h; div_start_i = ds; div_done_i = dd; jump_flag_i = jf;
      jump_addr_i = ja; if_wait_i = iw; mem_wait_i = mw;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      hold_id_i = 0; div_start_i = 0; div_done_i = 0; jump_flag_i = 0;
      jump_addr_i = '0; if_wait_i = 0; mem_wait_i = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      idle();
      n_vec++;
      if ({stall_o, flush_o, redirect_o} !== 11'b0) begin
         n_bad++; $display("FAIL reset_ctrl got %b_%b_%b exp 0", stall_o, flush_o, redirect_o);
      end
      n_vec++;
      if (redirect_addr_o !== 64'h0) begin
         n_bad++; $display("FAIL reset_addr got %h exp 0", redirect_addr_o);
      end
      n_vec++;
      if (div_err_o !== 1'b0) begin
         n_bad++; $display("FAIL reset_err got %b exp 0", div_err_o);
      end
      n_vec++;
      if ({stall_cnt_o, flush_cnt_o} !== 64'h0) begin
         n_bad++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", stall_cnt_o, flush_cnt_o);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      n_vec++;
      if ({stall_o, flush_o, redirect_o} !== {5'b00011, 5'b00100, 1'b0}) begin
         n_bad++; $display("FAIL ldu_ctrl got %b_%b_%b exp 00011_00100_0", stall_o, flush_o, redirect_o);
      end
      idle();
      n_vec++;
      if ({stall_o, flush_o, redirect_o} !== 11'b0 || stall_cnt_o !== 32'd1) begin
         n_bad++; $display("FAIL ldu_after got %b_%b_%b cnt %0d exp 0 cnt 1",
                           stall_o, flush_o, redirect_o, stall_cnt_o);
      end
   endtask

   task automatic test_divide();
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) idle();
         n_vec++;
         if ({stall_o, flush_o} !== {5'b00111, 5'b01000}) begin
            n_bad++; $display("FAIL div_hold cyc %0d got %b_%b exp 00111_01000", i, stall_o, flush_o);
         end
      end
      drive(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      n_vec++;
      if ({stall_o, flush_o} !== 10'b0) begin
         n_bad++; $display("FAIL div_done got %b_%b exp 0", stall_o, flush_o);
      end
      idle();
      n_vec++;
      if ({stall_o, flush_o} !== 10'b0 || stall_cnt_o !== 32'd5) begin
         n_bad++; $display("FAIL div_release got %b cnt %0d exp 0 cnt 5", stall_o, stall_cnt_o);
      end
      drive(1'b0, 1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      idle();
      n_vec++;
      if (stall_o !== 5'b0 || stall_cnt_o !== 32'd5) begin
         n_bad++; $display("FAIL div_zero_wait got %b cnt %0d exp 0 cnt 5", stall_o, stall_cnt_o);
      end
   endtask

   task automatic test_jump();
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1, JA, 1'b0, 1'b0);
      n_vec++;
      if ({stall_o, flush_o, redirect_o} !== {5'b00000, 5'b00110, 1'b1} || redirect_addr_o !== JA) begin
         n_bad++; $display("FAIL jump got %b_%b_%b %h exp 00000_00110_1 %h",
                           stall_o, flush_o, redirect_o, redirect_addr_o, JA);
      end
      idle();
      n_vec++;
      if (redirect_o !== 1'b0 || flush_cnt_o !== 32'd1) begin
         n_bad++; $display("FAIL jump_after got %b cnt %0d exp 0 cnt 1", redirect_o, flush_cnt_o);
      end
   endtask

   task automatic test_jump_mem_wait();
      do_reset();
      drive(1'b0, 1'b0, 1'b0, 1'b1, JA, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) drive(1'b0, 1'b0, 1'b0, 1'b0, {$urandom, $urandom}, 1'b0, 1'b1);
         n_vec++;
         if ({stall_o, flush_o, redirect_o} !== {5'b01111, 5'b10000, 1'b0}) begin
            n_bad++; $display("FAIL jmw_hold cyc %0d got %b_%b_%b exp 01111_10000_0",
                              i, stall_o, flush_o, redirect_o);
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 64'hDEAD_BEEF_0000_0040, 1'b0, 1'b0);
      n_vec++;
      if ({stall_o, flush_o, redirect_o} !== {5'b00000, 5'b00110, 1'b1} || redirect_addr_o !== JA) begin
         n_bad++; $display("FAIL jmw_redirect got %b_%b_%b %h exp 00000_00110_1 %h",
                           stall_o, flush_o, redirect_o, redirect_addr_o, JA);
      end
      idle();
      n_vec++;
      if (redirect_o !== 1'b0 || flush_cnt_o !== 32'd1 || stall_cnt_o !== 32'd3) begin
         n_bad++; $display("FAIL jmw_after got %b fc %0d sc %0d exp 0 fc 1 sc 3",
                           redirect_o, flush_cnt_o, stall_cnt_o);
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      for (int i = 0; i <= int'(TO); i++) begin
         if (i > 0) idle();
         n_vec++;
         if ({stall_o, div_err_o} !== {5'b00111, 1'b0}) begin
            n_bad++; $display("FAIL wd_hold cyc %0d got %b err %b exp 00111 err 0", i, stall_o, div_err_o);
         end
      end
      for (int i = 0; i < 3; i++) begin
         idle();
         n_vec++;
         if ({stall_o, div_err_o} !== {5'b00000, 1'b1}) begin
            n_bad++; $display("FAIL wd_err cyc %0d got %b err %b exp 00000 err 1", i, stall_o, div_err_o);
         end
      end
      n_vec++;
      if (stall_cnt_o !== 32'(TO + 1)) begin
         n_bad++; $display("FAIL wd_cnt got %0d exp %0d", stall_cnt_o, TO + 1);
      end
      do_reset();
      idle();
      n_vec++;
      if (div_err_o !== 1'b0) begin
         n_bad++; $display("FAIL wd_clear got %b exp 0", div_err_o);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) idle();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (stall_o !== 5'b0 || {stall_cnt_o, flush_cnt_o} !== 64'h0) begin
         n_bad++; $display("FAIL rstdiv_async got %b cnt %0d exp 0 cnt 0", stall_o, stall_cnt_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      n_vec++;
      if (stall_o !== 5'b0 || stall_cnt_o !== 32'd0) begin
         n_bad++; $display("FAIL rstdiv_run got %b cnt %0d exp 0 cnt 0", stall_o, stall_cnt_o);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, JA, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1);
      #2 rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      n_vec++;
      if (redirect_o !== 1'b0 || redirect_addr_o !== 64'h0 || flush_cnt_o !== 32'd0) begin
         n_bad++; $display("FAIL rstpend got %b %h cnt %0d exp 0 0 cnt 0",
                           redirect_o, redirect_addr_o, flush_cnt_o);
      end
   endtask

   task automatic test_random();
      bit          busy, pend, err;
      int          age, r;
      logic [63:0] paddr, ja, ea;
      logic [31:0] scnt, fcnt;
      logic        h, ds, dd, jf, iw, mw, er;
      logic [4:0]  es, ef;
      do_reset();
      busy = 0; pend = 0; err = 0; age = 0; paddr = '0; scnt = '0; fcnt = '0;
      for (int n = 0; n < 400; n++) begin
         h  = ($urandom_range(4) == 0);
         iw = ($urandom_range(3) == 0);
         mw = ($urandom_range(3) == 0);
         ja = {$urandom, $urandom};
         ds = 0; dd = 0; jf = 0;
         if (busy) dd = ($urandom_range(5) == 0);
         else if (pend) jf = ($urandom_range(2) == 0);
         else begin
            r = int'($urandom_range(9));
            if (r == 0) begin
               ds = 1; dd = ($urandom_range(3) == 0);
            end else if (r <= 2) jf = 1;
         end
         drive(h, ds, dd, jf, ja, iw, mw);

         n_vec++;
         if ({div_err_o, stall_cnt_o, flush_cnt_o} !== {err, scnt, fcnt}) begin
            n_bad++; $display("FAIL rnd_state n=%0d got err %b sc %0d fc %0d exp err %b sc %0d fc %0d",
                              n, div_err_o, stall_cnt_o, flush_cnt_o, err, scnt, fcnt);
         end

         es = '0; ef = '0; er = 0; ea = pend ? paddr : ja;
         if (mw) begin es = 5'b01111; ef = 5'b10000; end
         else if ((busy || ds) && !dd) begin es = 5'b00111; ef = 5'b01000; end
         else if (pend || jf) begin er = 1; ef = 5'b00110; end
         else if (h) begin es = 5'b00011; ef = 5'b00100; end
         else if (iw) begin es = 5'b00001; ef = 5'b00010; end

         n_vec++;
         if ({stall_o, flush_o, redirect_o} !== {es, ef, er}) begin
            n_bad++; $display("FAIL rnd_ctrl n=%0d got %b_%b_%b exp %b_%b_%b",
                              n, stall_o, flush_o, redirect_o, es, ef, er);
         end
         if (er) begin
            n_vec++;
            if (redirect_addr_o !== ea) begin
               n_bad++; $display("FAIL rnd_addr n=%0d got %h exp %h", n, redirect_addr_o, ea);
            end
         end

         scnt = scnt + 32'(es[0]);
         fcnt = fcnt + 32'(er);
         if (busy) begin
            if (dd) busy = 0;
            else begin
               age++;
               if (age >= int'(TO)) begin busy = 0; err = 1; end
            end
         end else if (pend) begin
            if (!mw) pend = 0;
         end else if (ds && !dd && !mw) begin
            busy = 1; age = 0;
         end else if (jf && mw) begin
            pend = 1; paddr = ja;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout exceeded");
      $fatal(1, "bench timeout");
   end

   initial begin
      n_vec = 0; n_bad = 0;
      rst_n = 1'b0;
      hold_id_i = 0; div_start_i = 0; div_done_i = 0; jump_flag_i = 0;
      jump_addr_i = '0; if_wait_i = 0; mem_wait_i = 0;
      test_reset();
      test_load_use();
      test_divide();
      test_jump();
      test_jump_mem_wait();
      test_watchdog();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
